// File: rtl/fir_out_stage.sv
// fir_out_stage: rounds, saturates and optionally decimates the FIR accumulator,
// then buffers results in a small FIFO drained over a valid/ready handshake.
// Optional feature macro: FIR_OUT_STICKY_SAT_EN (sticky saturation flag).
module fir_out_stage #(
    parameter int unsigned IW    = 16,
    parameter int unsigned TW    = 16,
    parameter int unsigned OW    = IW + TW + 8,
    parameter int unsigned OUTW  = 16,
    parameter int unsigned SHIFT = 15,
    parameter int unsigned DECIM = 1,
    parameter int unsigned DEPTH = 4
) (
    input  logic                   i_clk,
    input  logic                   i_reset,
    input  logic                   i_ce,
    input  logic                   i_valid,
    input  logic [OW-1:0]          i_acc,
    input  logic                   i_flush,
    output logic [OUTW-1:0]        o_m_data,
    output logic                   o_m_valid,
    input  logic                   i_m_ready,
    output logic [$clog2(DEPTH):0] o_fill,
    output logic                   o_overrun,
    output logic [7:0]             o_drop_cnt,
    output logic                   o_sat_sticky
);

    localparam int unsigned AW  = $clog2(DEPTH);
    localparam int unsigned FW  = AW + 1;
    localparam int unsigned DCW = (DECIM > 1) ? $clog2(DECIM) : 1;

    localparam logic [OW:0]        RND     = (OW+1)'(1) << (SHIFT - 1);
    localparam logic signed [OW:0] SAT_MAX = $signed(((OW+1)'(1) << (OUTW - 1)) - (OW+1)'(1));
    localparam logic signed [OW:0] SAT_MIN = ~SAT_MAX;

    logic                   accept;
    logic                   keep;
    logic [DCW-1:0]         dec_cnt;

    logic [OW:0]            r1;
    logic                   v1;
    logic signed [OW:0]     shifted;
    logic                   hi_clip;
    logic                   lo_clip;
    logic [OUTW-1:0]        sat_val;

    logic [OUTW-1:0]        s2;
    logic                   v2;

    logic [OUTW-1:0]        mem [DEPTH];
    logic [AW-1:0]          wr_ptr;
    logic [AW-1:0]          rd_ptr;
    logic [FW-1:0]          fill;
    logic                   full;
    logic                   wr;
    logic                   pop;
    logic                   push;
    logic                   drop;

    assign accept = i_ce && i_valid;
    assign keep   = accept && (dec_cnt == '0);

    // Decimation counter: advances on every accept, only slot 0 is kept
    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            dec_cnt <= '0;
        end else if (i_flush) begin
            dec_cnt <= '0;
        end else if (accept) begin
            dec_cnt <= (dec_cnt == DCW'(DECIM - 1)) ? '0 : dec_cnt + DCW'(1);
        end
    end

    // Stage 1: sign-extend and add the half-LSB rounding constant
    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            v1 <= 1'b0;
            r1 <= '0;
        end else begin
            v1 <= keep && !i_flush;
            if (keep) begin
                r1 <= {i_acc[OW-1], i_acc} + RND;
            end
        end
    end

    assign shifted = $signed(r1) >>> SHIFT;
    assign hi_clip = shifted > SAT_MAX;
    assign lo_clip = shifted < SAT_MIN;

    // Clamp the shifted sum into the signed output range
    always_comb begin
        sat_val = shifted[OUTW-1:0];
        if (hi_clip) begin
            sat_val = SAT_MAX[OUTW-1:0];
        end else if (lo_clip) begin
            sat_val = SAT_MIN[OUTW-1:0];
        end
    end

    // Stage 2: register the saturated FIFO write candidate
    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            v2 <= 1'b0;
            s2 <= '0;
        end else begin
            v2 <= v1 && !i_flush;
            if (v1) begin
                s2 <= sat_val;
            end
        end
    end

    assign full = (fill == FW'(DEPTH));
    assign wr   = v2 && !i_flush;
    assign pop  = (fill != '0) && i_m_ready && !i_flush;
    assign push = wr && (!full || pop);
    assign drop = wr && full && !pop;

    // FIFO storage; data is left stale on flush since fill gates validity
    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else if (push) begin
            mem[wr_ptr] <= s2;
        end
    end

    // FIFO pointers and occupancy
    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            fill   <= '0;
        end else if (i_flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            fill   <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            if (push && !pop) begin
                fill <= fill + FW'(1);
            end else if (pop && !push) begin
                fill <= fill - FW'(1);
            end
        end
    end

    // Overrun pulse and saturating drop counter (count survives flush)
    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            o_overrun  <= 1'b0;
            o_drop_cnt <= '0;
        end else if (i_flush) begin
            o_overrun  <= 1'b0;
        end else begin
            o_overrun <= drop;
            if (drop && (o_drop_cnt != 8'hFF)) begin
                o_drop_cnt <= o_drop_cnt + 8'd1;
            end
        end
    end

`ifdef FIR_OUT_STICKY_SAT_EN
    logic sat2;

    // Saturation tag travels with the stage-2 sample
    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            sat2 <= 1'b0;
        end else if (v1) begin
            sat2 <= hi_clip || lo_clip;
        end
    end

    // Sticky flag set only when a clipped sample actually enters the FIFO
    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            o_sat_sticky <= 1'b0;
        end else if (i_flush) begin
            o_sat_sticky <= 1'b0;
        end else if (push && sat2) begin
            o_sat_sticky <= 1'b1;
        end
    end
`else
    assign o_sat_sticky = 1'b0;
`endif

    assign o_m_data  = mem[rd_ptr];
    assign o_m_valid = (fill != '0);
    assign o_fill    = fill;

endmodule

// File: tb/tb_fir_out_stage.sv
// tb_fir_out_stage: directed and randomized checks of fir_out_stage against a
// queue-based behavioural model (DECIM=1 instance) and a decimation scoreboard
// (DECIM=3 instance, always ready).
module tb_fir_out_stage;

    localparam int OW    = 40;
    localparam int SHIFT = 15;
    localparam int DEPTH = 4;
`ifdef FIR_OUT_STICKY_SAT_EN
    localparam bit STICKY_ON = 1'b1;
`else
    localparam bit STICKY_ON = 1'b0;
`endif

    typedef struct packed {
        logic [15:0] val;
        logic        sat;
        int          due;
    } item_t;

    logic          clk   = 1'b0;
    logic          rst   = 1'b1;
    logic          ce    = 1'b0;
    logic          vld   = 1'b0;
    logic          flush = 1'b0;
    logic          ready = 1'b0;
    logic [OW-1:0] acc   = '0;
    bit            go    = 1'b0;

    logic [15:0] data,  data3;
    logic        mval,  mval3;
    logic [2:0]  fill,  fill3;
    logic        ovr,   ovr3;
    logic [7:0]  dcnt,  dcnt3;
    logic        stk,   stk3;

    int n_checks = 0;
    int n_pass   = 0;

    fir_out_stage dut (
        .i_clk(clk), .i_reset(rst), .i_ce(ce), .i_valid(vld), .i_acc(acc),
        .i_flush(flush), .o_m_data(data), .o_m_valid(mval), .i_m_ready(ready),
        .o_fill(fill), .o_overrun(ovr), .o_drop_cnt(dcnt), .o_sat_sticky(stk)
    );

    fir_out_stage #(.DECIM(3)) dut3 (
        .i_clk(clk), .i_reset(rst), .i_ce(ce), .i_valid(vld), .i_acc(acc),
        .i_flush(flush), .o_m_data(data3), .o_m_valid(mval3), .i_m_ready(1'b1),
        .o_fill(fill3), .o_overrun(ovr3), .o_drop_cnt(dcnt3), .o_sat_sticky(stk3)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input longint act, input longint exp);
        n_checks++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    endtask

    // Reference arithmetic: floor((acc + 2^(SHIFT-1)) / 2^SHIFT), clamped to int16
    function automatic logic [16:0] ref_out(input logic [OW-1:0] a_in);
        longint a, q;
        a = longint'($signed(a_in));
        q = (a + (longint'(1) <<< (SHIFT - 1))) >>> SHIFT;
        if (q > 32767)       return {1'b1, 16'h7FFF};
        else if (q < -32768) return {1'b1, 16'h8000};
        else                 return {1'b0, 16'(q)};
    endfunction

    // Behavioural model state
    item_t       infl[$];
    logic [15:0] fq[$];
    logic [15:0] exp3[$];
    logic [15:0] got3[$];
    int          cyc      = 0;
    int          cnt3     = 0;
    bit          m_ovr    = 1'b0;
    bit          m_sticky = 1'b0;
    int          m_drop   = 0;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            infl.delete(); fq.delete(); exp3.delete();
            m_ovr = 0; m_sticky = 0; m_drop = 0; cnt3 = 0;
        end else if (flush) begin
            infl.delete(); fq.delete(); exp3.delete();
            m_ovr = 0; m_sticky = 0; cnt3 = 0;
        end else begin
            bit    has_wr, do_pop, was_full;
            item_t it;
            logic [16:0] r;
            has_wr   = (infl.size() > 0) && (infl[0].due == cyc);
            do_pop   = (fq.size() > 0) && ready;
            was_full = (fq.size() == DEPTH);
            if (do_pop) void'(fq.pop_front());
            m_ovr = 0;
            if (has_wr) begin
                it = infl.pop_front();
                if (was_full && !do_pop) begin
                    m_ovr = 1;
                    if (m_drop < 255) m_drop++;
                end else begin
                    fq.push_back(it.val);
                    if (STICKY_ON && it.sat) m_sticky = 1;
                end
            end
            if (ce && vld) begin
                r = ref_out(acc);
                infl.push_back('{val: r[15:0], sat: r[16], due: cyc + 2});
                if (cnt3 == 0) exp3.push_back(r[15:0]);
                cnt3 = (cnt3 + 1) % 3;
            end
        end
        cyc++;
    end

    // Per-cycle comparison of both instances against the model
    always @(negedge clk) begin
        if (go) begin
            chk("valid", longint'(mval), longint'(fq.size() != 0));
            chk("fill", longint'(fill), longint'(fq.size()));
            if (fq.size() != 0) chk("data", longint'(data), longint'(fq[0]));
            chk("overrun", longint'(ovr), longint'(m_ovr));
            chk("drop_cnt", longint'(dcnt), longint'(m_drop));
            chk("sticky", longint'(stk), longint'(m_sticky));
            if (mval3) begin
                got3.push_back(data3);
                chk("dec_pending", longint'(exp3.size() != 0), 1);
                if (exp3.size() != 0) begin
                    chk("dec_data", longint'(data3), longint'(exp3[0]));
                    void'(exp3.pop_front());
                end
            end
        end
    end

    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    task automatic accept_one(input logic [OW-1:0] v);
        ce = 1'b1; vld = 1'b1; acc = v;
        tick();
        ce = 1'b0; vld = 1'b0;
    endtask

    function automatic logic [OW-1:0] units(input longint k);
        return OW'(k <<< SHIFT);
    endfunction

    initial begin
        logic [15:0] exp1 [4];
        int          ovr_cycles;
        longint      v;

        // Reset state
        tick(); tick();
        go = 1'b1;
        chk("rst_valid", longint'(mval), 0);
        chk("rst_fill", longint'(fill), 0);
        chk("rst_data", longint'(data), 0);
        chk("rst_overrun", longint'(ovr), 0);
        chk("rst_drop", longint'(dcnt), 0);
        chk("rst_sticky", longint'(stk), 0);
        rst = 1'b0;
        tick();

        // Rounding and three-edge latency
        ready = 1'b0;
        accept_one(OW'(16384));
        chk("lat_n0", longint'(mval), 0);
        tick();
        chk("lat_n1", longint'(mval), 0);
        tick();
        chk("lat_n2", longint'(mval), 1);
        chk("round_16384", longint'(data), 16'h0001);
        accept_one(OW'(16383));
        accept_one(OW'(-16385));
        accept_one(OW'(-16384));
        tick(); tick();
        chk("round_fill", longint'(fill), 4);
        exp1[0] = 16'h0001; exp1[1] = 16'h0000; exp1[2] = 16'hFFFF; exp1[3] = 16'h0000;
        for (int i = 0; i < 4; i++) begin
            chk("round_seq", longint'(data), longint'(exp1[i]));
            ready = 1'b1; tick(); ready = 1'b0;
        end
        chk("round_empty", longint'(fill), 0);

        // Saturation and sticky flag
        accept_one(OW'(longint'(1) <<< 31));
        accept_one(OW'(-(longint'(1) <<< 31)));
        tick(); tick();
        chk("sat_hi", longint'(data), 16'h7FFF);
        chk("sat_sticky", longint'(stk), longint'(STICKY_ON));
        ready = 1'b1; tick(); ready = 1'b0;
        chk("sat_lo", longint'(data), 16'h8000);
        flush = 1'b1; tick(); flush = 1'b0;
        chk("flush_sticky", longint'(stk), 0);
        chk("flush_fill", longint'(fill), 0);

        // Overflow: six writes into a four-entry FIFO with no reader
        ovr_cycles = 0;
        for (int k = 1; k <= 6; k++) begin
            accept_one(units(k));
            if (ovr) ovr_cycles++;
        end
        for (int i = 0; i < 4; i++) begin
            tick();
            if (ovr) ovr_cycles++;
        end
        chk("ovf_fill", longint'(fill), 4);
        chk("ovf_pulses", longint'(ovr_cycles), 2);
        chk("ovf_drop", longint'(dcnt), 2);
        ready = 1'b1;
        for (int k = 1; k <= 4; k++) begin
            chk("ovf_order", longint'(data), longint'(k));
            tick();
        end
        ready = 1'b0;
        chk("ovf_drained", longint'(fill), 0);

        // Full FIFO with a write and a pop on the same edge
        for (int k = 10; k <= 13; k++) accept_one(units(k));
        accept_one(units(14));
        tick();
        chk("fullpop_pre", longint'(fill), 4);
        ready = 1'b1; tick(); ready = 1'b0;
        chk("fullpop_ovr", longint'(ovr), 0);
        chk("fullpop_fill", longint'(fill), 4);
        chk("fullpop_drop", longint'(dcnt), 2);
        ready = 1'b1;
        for (int k = 11; k <= 14; k++) begin
            chk("fullpop_order", longint'(data), longint'(k));
            tick();
        end

        // Decimation by three on the second instance
        flush = 1'b1; tick(); flush = 1'b0;
        got3.delete();
        for (int k = 1; k <= 9; k++) accept_one(units(k));
        for (int i = 0; i < 5; i++) tick();
        chk("dec_count", longint'(got3.size()), 3);
        if (got3.size() == 3) begin
            chk("dec_0", longint'(got3[0]), 1);
            chk("dec_1", longint'(got3[1]), 4);
            chk("dec_2", longint'(got3[2]), 7);
        end

        // Async reset with samples in the pipeline and the FIFO
        ready = 1'b0;
        for (int k = 1; k <= 5; k++) accept_one(units(k));
        chk("mid_fill", longint'(fill), 3);
        rst = 1'b1;
        #1;
        chk("arst_valid", longint'(mval), 0);
        chk("arst_fill", longint'(fill), 0);
        chk("arst_data", longint'(data), 0);
        chk("arst_drop", longint'(dcnt), 0);
        tick(); tick();
        rst = 1'b0;
        for (int i = 0; i < 4; i++) begin
            tick();
            chk("arst_quiet", longint'(fill), 0);
        end

        // Flush coinciding with an accept discards that sample
        accept_one(units(5));
        tick(); tick();
        chk("pre_flush", longint'(fill), 1);
        flush = 1'b1; ce = 1'b1; vld = 1'b1; acc = units(6);
        tick();
        flush = 1'b0; ce = 1'b0; vld = 1'b0;
        chk("flush_acc_fill", longint'(fill), 0);
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("flush_acc_quiet", longint'(fill), 0);
        end
        accept_one(units(3));
        tick(); tick();
        chk("post_flush", longint'(data), 3);
        ready = 1'b1; tick();

        // Randomized traffic
        for (int n = 0; n < 600; n++) begin
            ce    = ($urandom_range(0, 3) != 0);
            vld   = ($urandom_range(0, 2) != 0);
            ready = 1'($urandom_range(0, 1));
            flush = ($urandom_range(0, 39) == 0);
            case ($urandom_range(0, 2))
                0: acc = OW'({$urandom(), $urandom()});
                1: begin
                    v = longint'($urandom_range(0, 8388608)) - 4194304;
                    acc = OW'(v);
                end
                default: begin
                    v = longint'($urandom_range(0, 200)) - 100;
                    acc = OW'((v <<< SHIFT) + 16384);
                end
            endcase
            tick();
        end
        ce = 1'b0; vld = 1'b0; flush = 1'b0; ready = 1'b1;
        for (int i = 0; i < 12; i++) tick();
        chk("final_fill", longint'(fill), 0);
        chk("final_dec_left", longint'(exp3.size()), 0);

        go = 1'b0;
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
